// File: rtl/lcd_bus_pkg.sv
// Shared constants, command codes and scan FSM encoding for the Model 100 LCD bus receiver.
package lcd_bus_pkg;

    localparam int NUM_DRIVERS = 10;
    localparam int COLS        = 50;
    localparam int FB_WIDTH    = 240;
    localparam int SYNC_STAGES = 2;

    localparam logic [7:0] CMD_ON   = 8'h39;
    localparam logic [7:0] CMD_OFF  = 8'h38;
    localparam logic [7:0] CMD_UP   = 8'h3B;
    localparam logic [7:0] CMD_DOWN = 8'h3A;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

endpackage

// File: rtl/lcd_bus_receiver_driver_state.sv
// One HD44102 column driver: page/column address, count direction and display-on flag.
module lcd_driver_state
    import lcd_bus_pkg::CMD_ON, lcd_bus_pkg::CMD_OFF, lcd_bus_pkg::CMD_UP, lcd_bus_pkg::CMD_DOWN;
#(
    parameter int COLS = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       cmd_valid,
    input  logic [7:0] cmd,
    input  logic       advance,
    output logic [1:0] page,
    output logic [5:0] col,
    output logic       up,
    output logic       on
);

    localparam logic [5:0] LAST_COL = 6'(COLS - 1);

    logic [1:0] page_q, page_d;
    logic [5:0] col_q, col_d;
    logic       up_q, up_d;
    logic       on_q, on_d;

    always_comb begin
        page_d = page_q;
        col_d  = col_q;
        up_d   = up_q;
        on_d   = on_q;
        if (clear) begin
            page_d = 2'd0;
            col_d  = 6'd0;
            up_d   = 1'b1;
            on_d   = 1'b0;
        end else if (cmd_valid) begin
            // Column-address codes occupy 0..COLS-1, so they never collide with the flag codes.
            if (cmd[5:0] <= LAST_COL) begin
                page_d = cmd[7:6];
                col_d  = cmd[5:0];
            end else begin
                case (cmd)
                    CMD_ON:   on_d = 1'b1;
                    CMD_OFF:  on_d = 1'b0;
                    CMD_UP:   up_d = 1'b1;
                    CMD_DOWN: up_d = 1'b0;
                    default:  ;
                endcase
            end
        end else if (advance) begin
            if (up_q) col_d = (col_q == LAST_COL) ? 6'd0 : col_q + 6'd1;
            else      col_d = (col_q == 6'd0) ? LAST_COL : col_q - 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page_q <= 2'd0;
            col_q  <= 6'd0;
            up_q   <= 1'b1;
            on_q   <= 1'b0;
        end else begin
            page_q <= page_d;
            col_q  <= col_d;
            up_q   <= up_d;
            on_q   <= on_d;
        end
    end

    assign page = page_q;
    assign col  = col_q;
    assign up   = up_q;
    assign on   = on_q;

endmodule

// File: rtl/lcd_bus_receiver.sv
// Model 100 LCD bus receiver: synchronizes the host bus, emulates the column drivers and
// turns every display-data write into framebuffer writes, one selected driver per cycle.
module lcd_bus_receiver
    import lcd_bus_pkg::scan_state_e, lcd_bus_pkg::ST_IDLE, lcd_bus_pkg::ST_SCAN;
#(
    parameter int NUM_DRIVERS = lcd_bus_pkg::NUM_DRIVERS,
    parameter int COLS        = lcd_bus_pkg::COLS,
    parameter int FB_WIDTH    = lcd_bus_pkg::FB_WIDTH,
    parameter int SYNC_STAGES = lcd_bus_pkg::SYNC_STAGES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             data_pin,
    input  logic [NUM_DRIVERS-1:0] cs_pin,
    input  logic                   cs1_pin,
    input  logic                   rw_pin,
    input  logic                   di_pin,
    input  logic                   enable_pin,
    input  logic                   reset_pin,
    output logic                   fb_we,
    output logic [7:0]             fb_x,
    output logic [2:0]             fb_y,
    output logic [7:0]             fb_data,
    output logic [NUM_DRIVERS-1:0] display_on,
    output logic                   overrun
);

    localparam int HALF = NUM_DRIVERS / 2;
    localparam int IW   = $clog2(NUM_DRIVERS);
    localparam int BW   = 13 + NUM_DRIVERS;

    logic [BW-1:0] sync_q [SYNC_STAGES];
    logic [BW-1:0] sync_d [SYNC_STAGES];
    logic          en_prev_q, en_prev_d;

    logic [7:0]             s_data;
    logic [NUM_DRIVERS-1:0] s_cs;
    logic                   s_cs1_n, s_rw, s_di, s_en, s_rst_n;
    logic                   strobe, clear;

    scan_state_e            state_q, state_d;
    logic [NUM_DRIVERS-1:0] pending_q, pending_d;
    logic [7:0]             byte_q, byte_d;
    logic                   fb_we_q, fb_we_d;
    logic [7:0]             fb_x_q, fb_x_d;
    logic [2:0]             fb_y_q, fb_y_d;
    logic [7:0]             fb_data_q, fb_data_d;
    logic                   overrun_q, overrun_d;

    logic [NUM_DRIVERS-1:0] cmd_valid, advance, active;
    logic [IW-1:0]          pick_idx;
    int                     x_full;
    logic [1:0]             drv_page [NUM_DRIVERS];
    logic [5:0]             drv_col  [NUM_DRIVERS];
    logic [NUM_DRIVERS-1:0] drv_on;
    logic [NUM_DRIVERS-1:0] unused_drv_up;

    // Every bus pin travels through the same stages so data and strobe stay aligned.
    always_comb begin
        sync_d[0] = {data_pin, cs_pin, cs1_pin, rw_pin, di_pin, enable_pin, reset_pin};
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    assign {s_data, s_cs, s_cs1_n, s_rw, s_di, s_en, s_rst_n} = sync_q[SYNC_STAGES-1];
    assign en_prev_d = s_en;
    assign clear     = ~s_rst_n;
    assign strobe    = en_prev_q & ~s_en & ~s_cs1_n & ~s_rw & (|s_cs) & s_rst_n;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        byte_d    = byte_q;
        fb_we_d   = 1'b0;
        fb_x_d    = fb_x_q;
        fb_y_d    = fb_y_q;
        fb_data_d = fb_data_q;
        overrun_d = strobe && (state_q == ST_SCAN);
        cmd_valid = '0;
        advance   = '0;
        active    = '0;
        pick_idx  = '0;
        x_full    = 0;

        // A data strobe issues its first write on the latch edge; later ones come from pending.
        if (strobe && state_q == ST_IDLE) begin
            if (s_di) begin
                active = s_cs;
                byte_d = s_data;
            end else begin
                cmd_valid = s_cs;
            end
        end else if (state_q == ST_SCAN) begin
            active = pending_q;
        end

        for (int d = NUM_DRIVERS - 1; d >= 0; d--) begin
            if (active[d]) pick_idx = IW'(d);
        end

        if (clear) begin
            state_d   = ST_IDLE;
            pending_d = '0;
            cmd_valid = '0;
        end else if (|active) begin
            advance[pick_idx]   = 1'b1;
            x_full              = (32'(pick_idx) % HALF) * COLS + 32'(drv_col[pick_idx]);
            fb_we_d             = (x_full < FB_WIDTH);
            fb_x_d              = x_full[7:0];
            fb_y_d              = {1'b0, drv_page[pick_idx]} + ((32'(pick_idx) >= HALF) ? 3'd4 : 3'd0);
            fb_data_d           = byte_d;
            pending_d           = active;
            pending_d[pick_idx] = 1'b0;
            state_d             = (|pending_d) ? ST_SCAN : ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            en_prev_q <= 1'b0;
            state_q   <= ST_IDLE;
            pending_q <= '0;
            byte_q    <= 8'd0;
            fb_we_q   <= 1'b0;
            fb_x_q    <= 8'd0;
            fb_y_q    <= 3'd0;
            fb_data_q <= 8'd0;
            overrun_q <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            en_prev_q <= en_prev_d;
            state_q   <= state_d;
            pending_q <= pending_d;
            byte_q    <= byte_d;
            fb_we_q   <= fb_we_d;
            fb_x_q    <= fb_x_d;
            fb_y_q    <= fb_y_d;
            fb_data_q <= fb_data_d;
            overrun_q <= overrun_d;
        end
    end

    for (genvar g = 0; g < NUM_DRIVERS; g++) begin : g_drv
        lcd_driver_state #(.COLS(COLS)) u_drv (
            .clk       (clk),
            .rst       (reset),
            .clear     (clear),
            .cmd_valid (cmd_valid[g]),
            .cmd       (s_data),
            .advance   (advance[g]),
            .page      (drv_page[g]),
            .col       (drv_col[g]),
            .up        (unused_drv_up[g]),
            .on        (drv_on[g])
        );
    end

    assign fb_we      = fb_we_q;
    assign fb_x       = fb_x_q;
    assign fb_y       = fb_y_q;
    assign fb_data    = fb_data_q;
    assign overrun    = overrun_q;
    assign display_on = drv_on;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Bench for lcd_bus_receiver: directed and random bus cycles, a panel model and a write scoreboard.
module tb_lcd_bus_receiver;

    localparam int ND   = 10;
    localparam int COLS = 50;
    localparam int FBW  = 240;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    data_pin = 8'd0;
    logic [ND-1:0] cs_pin = '0;
    logic          cs1_pin = 1'b1;
    logic          rw_pin = 1'b1;
    logic          di_pin = 1'b0;
    logic          enable_pin = 1'b1;
    logic          reset_pin = 1'b1;
    logic          fb_we;
    logic [7:0]    fb_x;
    logic [2:0]    fb_y;
    logic [7:0]    fb_data;
    logic [ND-1:0] display_on;
    logic          overrun;

    lcd_bus_receiver dut (
        .clk        (clk),
        .reset      (reset),
        .data_pin   (data_pin),
        .cs_pin     (cs_pin),
        .cs1_pin    (cs1_pin),
        .rw_pin     (rw_pin),
        .di_pin     (di_pin),
        .enable_pin (enable_pin),
        .reset_pin  (reset_pin),
        .fb_we      (fb_we),
        .fb_x       (fb_x),
        .fb_y       (fb_y),
        .fb_data    (fb_data),
        .display_on (display_on),
        .overrun    (overrun)
    );

    // ---- clock and cycle count ----
    always #10 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---- scoreboard state and panel model ----
    int          n_vec = 0;
    int          n_err = 0;
    logic [34:0] exp_q[$];
    logic [34:0] got_e;
    logic [34:0] exp_e;
    int          m_page[ND];
    int          m_col[ND];
    int          m_up[ND];
    int          m_on[ND];
    int          exp_ovr = 0;
    int          ovr_seen = 0;
    int unsigned strobe_cyc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            m_page[d] = 0;
            m_col[d]  = 0;
            m_up[d]   = 1;
            m_on[d]   = 0;
        end
    endtask

    // Applies one bus cycle to the model; writes beyond 'limit' are cut off by panel reset.
    task automatic model_txn(input logic [ND-1:0] cs, input logic cs1, input logic rw,
                             input logic di, input logic [7:0] b, input int limit);
        int i;
        int x;
        int y;
        i = 0;
        if (cs1 || rw || cs == '0) return;
        for (int d = 0; d < ND; d++) begin
            if (!cs[d]) continue;
            if (!di) begin
                if (int'(b[5:0]) < COLS) begin
                    m_page[d] = int'(b[7:6]);
                    m_col[d]  = int'(b[5:0]);
                end else if (b == 8'h39) m_on[d] = 1;
                else if (b == 8'h38) m_on[d] = 0;
                else if (b == 8'h3B) m_up[d] = 1;
                else if (b == 8'h3A) m_up[d] = 0;
            end else begin
                if (i < limit) begin
                    x = (d % 5) * COLS + m_col[d];
                    y = m_page[d] + ((d >= 5) ? 4 : 0);
                    if (x < FBW) exp_q.push_back({16'(strobe_cyc + 3 + i), 8'(x), 3'(y), b});
                    if (m_up[d] != 0) m_col[d] = (m_col[d] + 1) % COLS;
                    else m_col[d] = (m_col[d] + COLS - 1) % COLS;
                end
                i++;
            end
        end
    endtask

    task automatic check_on(input string name);
        logic [ND-1:0] v;
        for (int d = 0; d < ND; d++) v[d] = (m_on[d] != 0);
        check(name, longint'(display_on), longint'(v));
    endtask

    // ---- driver tasks ----
    task automatic set_bus(input logic [ND-1:0] cs, input logic cs1, input logic rw,
                           input logic di, input logic [7:0] b);
        cs_pin   = cs;
        cs1_pin  = cs1;
        rw_pin   = rw;
        di_pin   = di;
        data_pin = b;
    endtask

    task automatic bus_txn(input logic [ND-1:0] cs, input logic cs1, input logic rw,
                           input logic di, input logic [7:0] b);
        @(negedge clk);
        set_bus(cs, cs1, rw, di, b);
        @(negedge clk);
        enable_pin = 1'b0;
        strobe_cyc = cyc;
        model_txn(cs, cs1, rw, di, b, ND);
        repeat (3) @(negedge clk);
        enable_pin = 1'b1;
        repeat (18) @(negedge clk);
        set_bus('0, 1'b1, 1'b1, 1'b0, 8'd0);
    endtask

    // ---- monitor: pops one expectation per framebuffer write ----
    always @(negedge clk) begin
        if (!reset) begin
            if (overrun) ovr_seen++;
            if (fb_we) begin
                got_e = {cyc[15:0], fb_x, fb_y, fb_data};
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got x=%0d y=%0d data=0x%0h, no write expected",
                             fb_x, fb_y, fb_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("fb_write{cyc,x,y,data}", longint'(got_e), longint'(exp_e));
                end
            end
        end
    end

    // ---- stimulus ----
    initial begin
        logic [ND-1:0] r_cs;
        logic          r_di;
        logic [7:0]    r_b;
        int            sel;

        model_reset();
        repeat (3) @(negedge clk);
        check("reset_fb_we", longint'(fb_we), 0);
        check("reset_fb_x", longint'(fb_x), 0);
        check("reset_fb_y", longint'(fb_y), 0);
        check("reset_fb_data", longint'(fb_data), 0);
        check("reset_display_on", longint'(display_on), 0);
        check("reset_overrun", longint'(overrun), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // single driver address set and two data writes
        bus_txn(10'h001, 1'b0, 1'b0, 1'b0, 8'h45);
        bus_txn(10'h001, 1'b0, 1'b0, 1'b1, 8'hA5);
        bus_txn(10'h001, 1'b0, 1'b0, 1'b1, 8'h11);

        // driver 6 counting down through the column-0 wrap
        bus_txn(10'h040, 1'b0, 1'b0, 1'b0, 8'hC1);
        bus_txn(10'h040, 1'b0, 1'b0, 1'b0, 8'h3A);
        bus_txn(10'h040, 1'b0, 1'b0, 1'b1, 8'h01);
        bus_txn(10'h040, 1'b0, 1'b0, 1'b1, 8'h02);
        bus_txn(10'h040, 1'b0, 1'b0, 1'b1, 8'h03);

        // two drivers, top and bottom half
        bus_txn(10'h021, 1'b0, 1'b0, 1'b1, 8'h3C);

        // driver 4 past the framebuffer edge: no write, column still advances
        bus_txn(10'h010, 1'b0, 1'b0, 1'b0, 8'h2D);
        bus_txn(10'h010, 1'b0, 1'b0, 1'b1, 8'h77);
        bus_txn(10'h010, 1'b0, 1'b0, 1'b1, 8'h78);

        // ignored strobes, then display-on for drivers 1 and 4 only
        bus_txn(10'h3FF, 1'b1, 1'b0, 1'b0, 8'h39);
        bus_txn(10'h3FF, 1'b0, 1'b1, 1'b0, 8'h39);
        check_on("display_on_after_ignored");
        bus_txn(10'h012, 1'b0, 1'b0, 1'b0, 8'h39);
        check_on("display_on_selected");

        // overrun: second strobe four clocks after an all-driver data strobe
        @(negedge clk);
        set_bus(10'h3FF, 1'b0, 1'b0, 1'b1, 8'h5A);
        @(negedge clk);
        enable_pin = 1'b0;
        strobe_cyc = cyc;
        model_txn(10'h3FF, 1'b0, 1'b0, 1'b1, 8'h5A, ND);
        repeat (2) @(negedge clk);
        enable_pin = 1'b1;
        repeat (2) @(negedge clk);
        enable_pin = 1'b0;
        exp_ovr++;
        repeat (2) @(negedge clk);
        enable_pin = 1'b1;
        repeat (20) @(negedge clk);
        check("overrun_pulses", longint'(ovr_seen), longint'(exp_ovr));

        // panel reset five clocks into a scan
        @(negedge clk);
        set_bus(10'h3FF, 1'b0, 1'b0, 1'b1, 8'hC3);
        @(negedge clk);
        enable_pin = 1'b0;
        strobe_cyc = cyc;
        model_txn(10'h3FF, 1'b0, 1'b0, 1'b1, 8'hC3, 5);
        repeat (5) @(negedge clk);
        reset_pin  = 1'b0;
        enable_pin = 1'b1;
        model_reset();
        repeat (6) @(negedge clk);
        reset_pin = 1'b1;
        repeat (20) @(negedge clk);
        check_on("display_on_after_panel_reset");
        bus_txn(10'h200, 1'b0, 1'b0, 1'b1, 8'h99);

        // random bus cycles
        for (int n = 0; n < 40; n++) begin
            r_cs = ($urandom_range(0, 9) == 0) ? '0 : ND'($urandom_range(1, 1023));
            r_di = 1'($urandom_range(0, 1));
            sel  = $urandom_range(0, 4);
            r_b  = 8'($urandom);
            if (!r_di && sel == 1) r_b = 8'h39;
            if (!r_di && sel == 2) r_b = 8'h38;
            if (!r_di && sel == 3) r_b = 8'h3B;
            if (!r_di && sel == 4) r_b = 8'h3A;
            bus_txn(r_cs, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), r_di, r_b);
            check_on("display_on_random");
        end

        check("overrun_total", longint'(ovr_seen), longint'(exp_ovr));
        check("writes_outstanding", longint'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
